// File: rtl/fft_pkg.sv
// Shared constants and scheduler state encodings for the 8-point FFT frame path.
package fft_pkg;
    localparam int FFT_N         = 8;
    localparam int FFT_W         = 8;
    localparam int FFT_LAT_PAIRS = 3;
    localparam int FFT_BUS_W     = FFT_N * FFT_W;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_RUN   = 2'd1,
        SCH_DRAIN = 2'd2
    } sch_state_t;
endpackage

// File: rtl/fft_frame_packer.sv
// Serial-to-parallel input buffer: collects N samples into a frame for the scheduler.
module fft_frame_packer
    import fft_pkg::*;
#(
    parameter int W = FFT_W,
    parameter int N = FFT_N
) (
    input  logic           clk_1,
    input  logic           rst_n,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
    input  logic           clear,
    output logic           s_ready,
    output logic           full,
    output logic [N*W-1:0] frame
);
    localparam int FW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    logic [FW-1:0] fill_cnt;
    logic [W-1:0]  inbuf [N];

    assign s_ready = (fill_cnt < FW'(N));
    assign full    = (fill_cnt == FW'(N));

    // clear only arrives while full, so it never collides with a sample handshake
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            for (int i = 0; i < N; i++) inbuf[i] <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
        end else if (s_valid && s_ready) begin
            inbuf[fill_cnt[IW-1:0]] <= s_data;
            fill_cnt                <= fill_cnt + FW'(1);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_frame
        assign frame[g*W +: W] = inbuf[g];
    end
endmodule

// File: rtl/fft_frame_scheduler.sv
// Sequencer for the 8-point pipelined FFT datapath: frame issue, two-phase stage
// enables, result capture and serial drain with backpressure.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter int W         = FFT_W,
    parameter int N         = FFT_N,
    parameter int LAT_PAIRS = FFT_LAT_PAIRS
) (
    input  logic           clk_1,
    input  logic           rst_n,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [N*W-1:0] dp_in,
    output logic           dp_load,
    output logic           dp_ph1_en,
    output logic           dp_ph2_en,
    input  logic [N*W-1:0] dp_out,
    output logic [W-1:0]   m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic           busy,
    output logic [7:0]     frame_cnt
);
    localparam int PW = $clog2(2 * LAT_PAIRS);
    localparam int OW = $clog2(N);
    localparam logic [PW-1:0] P_LAST = PW'(2 * LAT_PAIRS - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N - 1);

    sch_state_t     state, state_nxt;
    logic [PW-1:0]  phase;
    logic [OW-1:0]  out_idx;
    logic [W-1:0]   outbuf [N];
    logic [N*W-1:0] inbuf_frame;
    logic           full, issue, capture, out_fire;

    fft_frame_packer #(.W(W), .N(N)) u_packer (
        .clk_1   (clk_1),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .clear   (issue),
        .s_ready (s_ready),
        .full    (full),
        .frame   (inbuf_frame)
    );

    always_ff @(posedge clk_1) begin
        if (!rst_n) state <= SCH_IDLE;
        else        state <= state_nxt;
    end

    // The dp_load cycle is the first RUN cycle; phases start the cycle after it
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        capture   = 1'b0;
        out_fire  = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = outbuf[out_idx];
        dp_ph1_en = 1'b0;
        dp_ph2_en = 1'b0;
        busy      = (state != SCH_IDLE);
        case (state)
            SCH_IDLE: begin
                if (full) begin
                    issue     = 1'b1;
                    state_nxt = SCH_RUN;
                end
            end
            SCH_RUN: begin
                if (!dp_load) begin
                    dp_ph1_en = ~phase[0];
                    dp_ph2_en = phase[0];
                    if (phase == P_LAST) begin
                        capture   = 1'b1;
                        state_nxt = SCH_DRAIN;
                    end
                end
            end
            SCH_DRAIN: begin
                m_valid = 1'b1;
                m_last  = (out_idx == O_LAST);
                if (m_ready) begin
                    out_fire = 1'b1;
                    if (out_idx == O_LAST) state_nxt = SCH_IDLE;
                end
            end
            default: state_nxt = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            dp_in     <= '0;
            dp_load   <= 1'b0;
            phase     <= '0;
            out_idx   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < N; i++) outbuf[i] <= '0;
        end else begin
            dp_load <= issue;
            if (issue) dp_in <= inbuf_frame;
            if (state == SCH_RUN && !dp_load)
                phase <= (phase == P_LAST) ? '0 : phase + PW'(1);
            if (capture)
                for (int i = 0; i < N; i++) outbuf[i] <= dp_out[i*W +: W];
            if (out_fire) begin
                if (out_idx == O_LAST) begin
                    out_idx   <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    out_idx <= out_idx + OW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench: behavioural FFT datapath model plus a frame-level scoreboard.
module tb_fft_frame_scheduler;
    localparam int LAT = 3;
    localparam real PI = 3.14159265358979323846;

    logic        clk_1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] dp_in;
    logic        dp_load, dp_ph1_en, dp_ph2_en;
    logic [63:0] dp_out = '0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last, busy;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    fft_frame_scheduler dut (
        .clk_1(clk_1), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dp_in(dp_in), .dp_load(dp_load), .dp_ph1_en(dp_ph1_en), .dp_ph2_en(dp_ph2_en),
        .dp_out(dp_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk_1 = ~clk_1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Real part of DFT bin k, rounded and truncated to 8 bits
    function automatic logic [7:0] fft_bin(input logic [63:0] f, input int k);
        real acc;
        int  r;
        acc = 0.0;
        for (int n = 0; n < 8; n++)
            acc += real'(int'(f[n*8 +: 8])) * $cos(2.0 * PI * real'(k * n) / 8.0);
        r = $rtoi(acc + ((acc >= 0.0) ? 0.5 : -0.5));
        return r[7:0];
    endfunction

    function automatic logic [63:0] pack8(input int a, b, c, d, e, f, g, h);
        logic [63:0] p;
        p = {h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
        return p;
    endfunction

    // Datapath model: latch at dp_load, result appears once LAT ph2 pulses have passed
    logic [63:0] lat_frame = '0;
    int          pairs = LAT;
    always @(negedge clk_1) begin
        if (dp_load) begin
            lat_frame = dp_in;
            pairs     = 0;
            dp_out    = {$urandom, $urandom};
        end else if (dp_ph2_en && pairs < LAT) begin
            pairs++;
            if (pairs == LAT)
                for (int k = 0; k < 8; k++) dp_out[k*8 +: 8] = fft_bin(lat_frame, k);
        end
    end

    logic [7:0]  sample_q[$];
    logic [63:0] frame_q[$];
    logic [7:0]  result_q[$];
    int          exp_fc = 0;
    int          since_load = -1;
    int          gap = -1;
    int          ph1c = 0, ph2c = 0;
    bit          first_seen = 1'b1;
    bit          held_valid = 1'b0;
    logic [7:0]  held_data = '0;
    logic [7:0]  first_out = '0;

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk_1) begin
        if (!rst_n) begin
            sample_q.delete(); frame_q.delete(); result_q.delete();
            exp_fc = 0; since_load = -1; gap = -1; first_seen = 1'b1; held_valid = 1'b0;
        end else begin
            if (gap >= 0) gap++;
            if (dp_load) begin
                if (frame_q.size() == 0) begin
                    checkOutput("dp_load_spurious", dp_load, 0);
                end else begin
                    logic [63:0] f;
                    f = frame_q.pop_front();
                    checkOutput("dp_in", dp_in, f);
                    for (int k = 0; k < 8; k++) result_q.push_back(fft_bin(f, k));
                end
                if (gap >= 0) begin
                    checkOutput("issue_gap", gap, 2);
                    gap = -1;
                end
                since_load = 0; ph1c = 0; ph2c = 0; first_seen = 1'b0;
            end else if (since_load >= 0 && !first_seen) begin
                since_load++;
                ph1c += int'(dp_ph1_en);
                ph2c += int'(dp_ph2_en);
            end
            checkOutput("s_ready", s_ready, frame_q.size() == 0);
            checkOutput("ph_overlap", dp_ph1_en & dp_ph2_en, 0);
            checkOutput("frame_cnt", frame_cnt, exp_fc[7:0]);
            if (held_valid) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, held_data);
            end
            held_valid = 1'b0;
            if (m_valid && !first_seen) begin
                checkOutput("latency", since_load, 7);
                checkOutput("ph1_count", ph1c, LAT);
                checkOutput("ph2_count", ph2c, LAT);
                first_seen = 1'b1;
            end
            if (s_valid && s_ready) begin
                sample_q.push_back(s_data);
                if (sample_q.size() == 8) begin
                    logic [63:0] f;
                    for (int i = 0; i < 8; i++) f[i*8 +: 8] = sample_q[i];
                    frame_q.push_back(f);
                    sample_q.delete();
                end
            end
            if (m_valid) begin
                if (result_q.size() == 0) begin
                    checkOutput("m_valid_spurious", m_valid, 0);
                end else begin
                    checkOutput("m_last", m_last, result_q.size() == 1);
                    if (m_ready) begin
                        if (result_q.size() == 8) first_out = m_data;
                        checkOutput("m_data", m_data, result_q[0]);
                        void'(result_q.pop_front());
                        if (result_q.size() == 0) begin
                            exp_fc = (exp_fc + 1) % 256;
                            if (frame_q.size() > 0) gap = 0;
                        end
                    end else begin
                        held_valid = 1'b1;
                        held_data  = m_data;
                    end
                end
            end
        end
    end

    int ready_mode = 0;
    initial begin
        int pidx = 0;
        forever begin
            @(posedge clk_1); #1;
            case (ready_mode)
                1:       m_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            pidx++;
        end
    end

    // Streams one frame; sample 0 is in1. Called and returns at posedge+1.
    task automatic applyStimulus(input logic [63:0] f, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            bit accepted;
            int tries;
            s_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk_1); #1; end
            s_valid = 1'b1;
            s_data  = f[i*8 +: 8];
            accepted = 1'b0;
            tries = 0;
            while (!accepted && tries < 400) begin
                @(negedge clk_1);
                accepted = s_ready;
                @(posedge clk_1); #1;
                tries++;
            end
            if (!accepted) checkOutput("s_timeout", accepted, 1);
        end
        s_valid = 1'b0;
    endtask

    task automatic waitDrained();
        bit done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge clk_1);
            done = (sample_q.size() == 0) && (frame_q.size() == 0) && (result_q.size() == 0) && !busy;
        end
        checkOutput("drain_timeout", done, 1);
        @(posedge clk_1); #1;
    endtask

    task automatic doReset();
        @(posedge clk_1); #1;
        rst_n = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk_1);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] f;
        bit seen;
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] f;
        bit seen;
        doReset();
        @(negedge clk_1);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dp_in", dp_in, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        @(posedge clk_1); #1;

        $display("[TB] stream 0..7, m_ready high");
        applyStimulus(pack8(0, 1, 2, 3, 4, 5, 6, 7), 0);
        waitDrained();
        checkOutput("ramp_bin0", first_out, 28);
        checkOutput("ramp_fc", frame_cnt, 1);

        $display("[TB] ramp with random gaps");
        applyStimulus(pack8(0, 1, 2, 3, 4, 5, 6, 7), 3);
        waitDrained();
        checkOutput("ramp2_bin0", first_out, 28);

        $display("[TB] backpressure 1,0,0,1");
        ready_mode = 1;
        applyStimulus({$urandom, $urandom}, 1);
        waitDrained();
        ready_mode = 0;

        $display("[TB] overlap");
        applyStimulus(pack8(0, 1, 2, 3, 4, 5, 6, 7), 0);
        applyStimulus(pack8(3, 2, 1, 8, 7, 4, 6, 5), 0);
        waitDrained();
        checkOutput("overlap_bin0", first_out, 36);

        $display("[TB] reset during RUN");
        applyStimulus(pack8(9, 9, 9, 9, 9, 9, 9, 9), 0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_1);
            seen = dp_load;
        end
        checkOutput("wait_dp_load", seen, 1);
        repeat (4) @(posedge clk_1);
        #1 checkOutput("p3_ph2", dp_ph2_en, 1);
        rst_n = 1'b0;
        @(posedge clk_1); #1 rst_n = 1'b1;
        @(negedge clk_1);
        checkOutput("mid_rst_dp_in", dp_in, 0);
        checkOutput("mid_rst_dp_load", dp_load, 0);
        checkOutput("mid_rst_ph1", dp_ph1_en, 0);
        checkOutput("mid_rst_ph2", dp_ph2_en, 0);
        checkOutput("mid_rst_m_valid", m_valid, 0);
        checkOutput("mid_rst_m_data", m_data, 0);
        checkOutput("mid_rst_m_last", m_last, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_fc", frame_cnt, 0);
        @(posedge clk_1); #1;
        applyStimulus(pack8(7, 6, 5, 4, 3, 2, 1, 0), 0);
        waitDrained();
        checkOutput("fresh_bin0", first_out, 28);
        checkOutput("fresh_fc", frame_cnt, 1);

        $display("[TB] random frames");
        ready_mode = 2;
        for (int n = 0; n < 20; n++) applyStimulus({$urandom, $urandom}, 4);
        waitDrained();
        ready_mode = 0;

        $display("[TB] 256 DC frames");
        doReset();
        f = pack8(1, 1, 1, 1, 1, 1, 1, 1);
        for (int n = 0; n < 256; n++) applyStimulus(f, 0);
        waitDrained();
        checkOutput("dc_bin0", first_out, 8);
        checkOutput("dc_wrap_fc", frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
